// File: rtl/cobrir_ctrl_n_if.sv
// rtl/cobrir_ctrl_n_if.sv - sensor, limit-switch and motor-command bundle for cobrir_ctrl_n
// Purpose: groups the weather sensors, per-cover limit switches, fault clear and
//          per-cover motor/fault outputs of the N-cover controller.
// Signals: S, C     shared sun / rain sensors (raw)
//          E, D     per-cover open / closed limit switches (raw), N bits
//          CLR      fault clear, all channels
//          FECHAR   per-cover close command, N bits
//          ABRIR    per-cover open command, N bits
//          FALHA    per-cover latched fault flag, N bits
// Modports: master drives sensors and reads commands; slave is the controller.
interface cobrir_ctrl_n_if #(
    parameter int N = 2
);
    logic         S;
    logic         C;
    logic [N-1:0] E;
    logic [N-1:0] D;
    logic         CLR;
    logic [N-1:0] FECHAR;
    logic [N-1:0] ABRIR;
    logic [N-1:0] FALHA;

    modport master (
        output S, C, E, D, CLR,
        input  FECHAR, ABRIR, FALHA
    );

    modport slave (
        input  S, C, E, D, CLR,
        output FECHAR, ABRIR, FALHA
    );
endinterface

// File: rtl/cobrir_ctrl_n.sv
// rtl/cobrir_ctrl_n.sv - N-channel debounced motorised cover controller
// Purpose: synchronises sun/rain sensors and limit switches, debounces the
//          sensors, and runs one Moore motor FSM per cover with dead time on
//          reversal, motion timeout and a latched, clearable fault.
// Ports:   clk    system clock, rising edge
//          rst_n  asynchronous active-low reset
//          bus    cobrir_ctrl_n_if slave: S, C, E[N], D[N], CLR in;
//                 FECHAR[N], ABRIR[N], FALHA[N] out
module cobrir_ctrl_n #(
    parameter int N        = 2,
    parameter int DEB_CYC  = 4,
    parameter int T_MAX    = 20,
    parameter int DEAD_CYC = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    cobrir_ctrl_n_if.slave bus
);
    // One timer serves both the motion timeout and the pause, so it is sized
    // for whichever limit is larger.
    localparam int TCAP = (T_MAX > DEAD_CYC) ? T_MAX : DEAD_CYC;
    localparam int TW   = $clog2(TCAP + 1);
    localparam int DW   = $clog2(DEB_CYC + 1);
    localparam int HOLD = DEB_CYC + 2;
    localparam int HW   = $clog2(HOLD + 1);

    localparam logic [TW-1:0] T_LAST    = TW'(T_MAX - 1);
    localparam logic [TW-1:0] DEAD_LAST = TW'(DEAD_CYC - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
    localparam logic [HW-1:0] HOLD_END  = HW'(HOLD);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FECHANDO,
        ST_ABRINDO,
        ST_PAUSA,
        ST_FALHA
    } state_t;

    // Weather channels packed as index 0 = S (sun), index 1 = C (rain).
    logic [1:0]    wx_meta_q, wx_sync_q;
    logic [1:0]    wx_filt_q, wx_filt_d;
    logic [DW-1:0] deb_cnt_q [2];
    logic [DW-1:0] deb_cnt_d [2];

    logic [N-1:0]  e_meta_q, e_sync_q;
    logic [N-1:0]  d_meta_q, d_sync_q;

    logic [HW-1:0] hold_q, hold_d;
    logic          hold_done;

    state_t        state_q [N];
    state_t        state_d [N];
    logic [TW-1:0] timer_q [N];
    logic [TW-1:0] timer_d [N];
    state_t        rest_nxt [N];

    logic          close_req, open_req;
    logic [N-1:0]  jam;
    logic [N-1:0]  fechar, abrir, falha;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wx_meta_q <= '0;
            wx_sync_q <= '0;
            wx_filt_q <= '0;
            e_meta_q  <= '0;
            e_sync_q  <= '0;
            d_meta_q  <= '0;
            d_sync_q  <= '0;
            hold_q    <= '0;
            for (int k = 0; k < 2; k++) begin
                deb_cnt_q[k] <= '0;
            end
            for (int i = 0; i < N; i++) begin
                state_q[i] <= ST_IDLE;
                timer_q[i] <= '0;
            end
        end else begin
            wx_meta_q <= {bus.C, bus.S};
            wx_sync_q <= wx_meta_q;
            wx_filt_q <= wx_filt_d;
            e_meta_q  <= bus.E;
            e_sync_q  <= e_meta_q;
            d_meta_q  <= bus.D;
            d_sync_q  <= d_meta_q;
            hold_q    <= hold_d;
            for (int k = 0; k < 2; k++) begin
                deb_cnt_q[k] <= deb_cnt_d[k];
            end
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
        end
    end

    // Debounce: any cycle of agreement restarts the count, so only a run of
    // DEB_CYC consecutive disagreeing samples moves the filtered value.
    always_comb begin
        wx_filt_d = wx_filt_q;
        for (int k = 0; k < 2; k++) begin
            deb_cnt_d[k] = '0;
            if (wx_sync_q[k] != wx_filt_q[k]) begin
                if (deb_cnt_q[k] == DEB_LAST) begin
                    wx_filt_d[k] = wx_sync_q[k];
                end else begin
                    deb_cnt_d[k] = deb_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    // Startup hold keeps every FSM parked until the filters have had time to
    // settle on the sensor levels present at reset release.
    assign hold_done = (hold_q == HOLD_END);
    assign hold_d    = hold_done ? hold_q : hold_q + 1'b1;

    assign close_req = wx_filt_q[0] | wx_filt_q[1];
    assign open_req  = ~close_req;
    assign jam       = e_sync_q & d_sync_q;

    // Decision taken from rest; a finished pause reuses it directly so the
    // outputs stay low for exactly DEAD_CYC cycles on a reversal.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (close_req && !d_sync_q[i]) begin
                rest_nxt[i] = ST_FECHANDO;
            end else if (open_req && !e_sync_q[i]) begin
                rest_nxt[i] = ST_ABRINDO;
            end else if (jam[i]) begin
                rest_nxt[i] = ST_FALHA;
            end else begin
                rest_nxt[i] = ST_IDLE;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    state_d[i] = rest_nxt[i];
                end
                ST_FECHANDO: begin
                    if (jam[i]) begin
                        state_d[i] = ST_FALHA;
                    end else if (d_sync_q[i]) begin
                        state_d[i] = ST_IDLE;
                    end else if (open_req) begin
                        state_d[i] = ST_PAUSA;
                    end else if (timer_q[i] == T_LAST) begin
                        state_d[i] = ST_FALHA;
                    end else begin
                        timer_d[i] = timer_q[i] + 1'b1;
                    end
                end
                ST_ABRINDO: begin
                    if (jam[i]) begin
                        state_d[i] = ST_FALHA;
                    end else if (e_sync_q[i]) begin
                        state_d[i] = ST_IDLE;
                    end else if (close_req) begin
                        state_d[i] = ST_PAUSA;
                    end else if (timer_q[i] == T_LAST) begin
                        state_d[i] = ST_FALHA;
                    end else begin
                        timer_d[i] = timer_q[i] + 1'b1;
                    end
                end
                ST_PAUSA: begin
                    if (timer_q[i] == DEAD_LAST) begin
                        state_d[i] = rest_nxt[i];
                    end else begin
                        timer_d[i] = timer_q[i] + 1'b1;
                    end
                end
                ST_FALHA: begin
                    if (bus.CLR && !jam[i]) begin
                        state_d[i] = ST_PAUSA;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase
            if (!hold_done) begin
                state_d[i] = ST_IDLE;
            end
            // Every state entry starts the shared timer from zero.
            if (state_d[i] != state_q[i]) begin
                timer_d[i] = '0;
            end
        end
    end

    always_comb begin
        fechar = '0;
        abrir  = '0;
        falha  = '0;
        for (int i = 0; i < N; i++) begin
            fechar[i] = (state_q[i] == ST_FECHANDO);
            abrir[i]  = (state_q[i] == ST_ABRINDO);
            falha[i]  = (state_q[i] == ST_FALHA);
        end
    end

    assign bus.FECHAR = fechar;
    assign bus.ABRIR  = abrir;
    assign bus.FALHA  = falha;
endmodule
